// File: rtl/memory_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
// The memory completes an access by raising mem_ready, with load data on mem_rdata in the same cycle.
interface memory_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: latches execute results, runs loads/stores over a req/ready bus
// with an optional timeout, and presents a registered write-back bundle.
module memory_access #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_rs2_value,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic        ex_RegWrite,
    input  logic [4:0]  ex_RegDest,
    output logic        stall,
    memory_access_if.master mem,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_RegDest,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err
);
    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] waitCnt;
    logic [1:0]       off_p1;
    logic [2:0]       funct3_p1;
    logic             regWrite_p1;
    logic [4:0]       regDest_p1;

    logic        isMem;
    logic        illegal;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] wdata;

    // Shift the addressed lane down, then sign- or zero-extend by access size.
    function automatic logic [31:0] formatLoad(input logic [31:0] rdata,
                                               input logic [1:0]  laneOff,
                                               input logic [2:0]  f3);
        logic [31:0] sh;
        sh = rdata >> {laneOff, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        off     = ex_result[1:0];
        isMem   = ex_MemRead | ex_MemWrite;
        illegal = 1'b0;
        strb    = 4'b0000;
        wdata   = ex_rs2_value;
        case (ex_funct3[1:0])
            2'b00: begin
                strb  = 4'b0001 << off;
                wdata = {4{ex_rs2_value[7:0]}};
            end
            2'b01: begin
                strb    = 4'b0011 << off;
                wdata   = {2{ex_rs2_value[15:0]}};
                illegal = off[0];
            end
            2'b10: begin
                strb    = 4'b1111;
                illegal = (off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        // Both-direction ops, funct3 11x and unsigned stores have no meaning on this bus.
        if ((ex_MemRead & ex_MemWrite) | (ex_funct3[2] & ex_funct3[1]) | (ex_MemWrite & ex_funct3[2]))
            illegal = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            waitCnt       <= '0;
            stall         <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            off_p1        <= '0;
            funct3_p1     <= '0;
            regWrite_p1   <= 1'b0;
            regDest_p1    <= '0;
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_RegDest    <= '0;
            wb_data       <= '0;
            misaligned    <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!isMem) begin
                            wb_valid    <= 1'b1;
                            wb_data     <= ex_result;
                            wb_RegDest  <= ex_RegDest;
                            wb_RegWrite <= ex_RegWrite & (ex_RegDest != 5'd0);
                        end else if (illegal) begin
                            misaligned  <= 1'b1;
                            wb_valid    <= 1'b1;
                            wb_RegDest  <= ex_RegDest;
                            wb_RegWrite <= 1'b0;
                        end else begin
                            // ---- stage boundary: execute -> memory access (WAIT) ----
                            state         <= WAIT;
                            stall         <= 1'b1;
                            waitCnt       <= '0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= ex_MemWrite;
                            mem.mem_addr  <= {ex_result[31:2], 2'b00};
                            mem.mem_wdata <= wdata;
                            mem.mem_wstrb <= ex_MemWrite ? strb : 4'b0000;
                            off_p1        <= off;
                            funct3_p1     <= ex_funct3;
                            regWrite_p1   <= ex_RegWrite & (ex_RegDest != 5'd0);
                            regDest_p1    <= ex_RegDest;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_ready) begin
                        // ---- stage boundary: memory access -> write-back ----
                        state       <= IDLE;
                        stall       <= 1'b0;
                        mem.mem_req <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_RegDest  <= regDest_p1;
                        wb_RegWrite <= mem.mem_we ? 1'b0 : regWrite_p1;
                        wb_data     <= mem.mem_we ? 32'd0 : formatLoad(mem.mem_rdata, off_p1, funct3_p1);
                    end else if ((WAIT_TIMEOUT != 0) && (waitCnt == CNT_LAST)) begin
                        state       <= IDLE;
                        stall       <= 1'b0;
                        mem.mem_req <= 1'b0;
                        bus_err     <= 1'b1;
                        wb_valid    <= 1'b1;
                        wb_RegDest  <= regDest_p1;
                        wb_RegWrite <= 1'b0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Latches the execute result and control signals, then issues loads and stores to the data memory over a req/ready handshake.
- Stalls upstream while an access is outstanding.
- Formats load data and presents a registered write-back bundle to the register bank.

Parameters:
- WAIT_TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ready before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute stage presents an instruction
- ex_result  in  32  ALU result: memory address for loads/stores, write-back value otherwise
- ex_rs2_value  in  32  store data
- ex_funct3  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- ex_MemRead  in  1  instruction is a load
- ex_MemWrite  in  1  instruction is a store
- ex_RegWrite  in  1  instruction writes a register
- ex_RegDest  in  5  destination register
- stall  out  1  upstream must hold ex_* stable; ex_* are ignored while high
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address: {addr[31:2],2'b00}
- mem_wdata  out  32  store data replicated across lanes
- mem_wstrb  out  4  byte-lane enables
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  32  load data, valid when mem_ready
- wb_valid  out  1  one-cycle pulse, write-back bundle valid
- wb_RegWrite  out  1  write enable to the register bank
- wb_RegDest  out  5  destination register
- wb_data  out  32  write-back value
- misaligned  out  1  one-cycle pulse: misaligned address or illegal access
- bus_err  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timeout counter=0. Every output is 0, including mem_addr, mem_wdata, mem_wstrb and wb_data. A request outstanding at reset is abandoned and mem_req drops immediately.
- States: IDLE, WAIT. stall = (state==WAIT), registered, with no combinational path from mem_ready.
- IDLE with ex_valid=0: wb_valid, misaligned and bus_err are 0 at the next edge.
- IDLE with ex_valid=1, non-memory instruction: at the next edge wb_valid=1, wb_data=ex_result, wb_RegDest=ex_RegDest, wb_RegWrite=ex_RegWrite. Latency 1.
- IDLE with ex_valid=1, memory instruction that is legal and aligned: at the next edge state=WAIT, mem_req=1, mem_we=ex_MemWrite. Address, data, strobes, funct3 byte offset and destination are latched and held stable while mem_req=1.
- Illegal or misaligned access (no memory request; misaligned=1 and wb_valid=1 with wb_RegWrite=0 at the next edge):
  - ex_MemRead and ex_MemWrite both set.
  - funct3 in {011, 110, 111}.
  - Store with funct3 in {100, 101}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- Store strobes: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- Store data: byte = {4{rs2[7:0]}}; half = {2{rs2[15:0]}}; word = rs2.
- Loads: the lane selected by the latched addr[1:0] is extracted from mem_rdata, then sign- or zero-extended according to funct3.
- WAIT with mem_ready=1: at the edge, state=IDLE, mem_req=0, wb_valid=1.
  - Load: wb_data = formatted load data, wb_RegWrite = latched RegWrite.
  - Store: wb_RegWrite=0, wb_data=0.
  - The next instruction is accepted no earlier than the following cycle, so minimum memory-op occupancy is 2 cycles.
- WAIT timeout: counter resets on entry to WAIT and increments each WAIT cycle with mem_ready=0. When it reaches WAIT_TIMEOUT (nonzero): state=IDLE, mem_req=0, bus_err=1, wb_valid=1, wb_RegWrite=0. mem_ready in the same cycle as expiry wins, and the access completes normally.
- RegDest 0: wb_RegWrite is forced to 0 in all cases.
- wb_valid, misaligned and bus_err are single-cycle pulses. Outside pulses, wb_* retain their last values.

Test Plan:
- Reset mid-WAIT: store to 0x100 pending, drop rst → mem_req, stall and all outputs go to 0 immediately; after release, state is IDLE and the next instruction is accepted.
- ALU op: ex_result=0x1234, RegDest=5, RegWrite=1 → one cycle later wb_valid=1, wb_data=0x1234, wb_RegDest=5; stall stays 0; back-to-back ops each write back 1 cycle later.
- LB at 0x1003 with mem_rdata=0x80AABBCC, mem_ready 3 cycles after req:
  - mem_addr=0x1000, mem_we=0.
  - stall high for 3 cycles.
  - wb_data=0xFFFFFF80.
  - Same access as LBU → wb_data=0x00000080.
- SH at 0x2002, rs2=0xDEADBEEF, mem_ready in first WAIT cycle → mem_wdata=0xBEEFBEEF, mem_wstrb=1100, mem_we=1; wb_valid=1 with wb_RegWrite=0.
- Misaligned LW at 0x3001, and illegal funct3=011 → no mem_req; misaligned pulses one cycle; wb_RegWrite=0.
- WAIT_TIMEOUT=4, mem_ready never asserted → mem_req high exactly 4 cycles, then bus_err and wb_valid pulse; stall released; a following load completes normally.
